pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Parametrised inter-stage pipeline register with valid/ready handshake, optional two-entry skid buffer, flush and global hold. It generalises the fixed IF/ID latch into one block that can be instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with arbitrary payload width. Upstream stages drive `in_*` and downstream stages consume `out_*`. The hazard unit drives `flush`, and the cache hit logic drives `hold`.

## Interface
- `DATA_W`, default 64: payload width in bits (e.g. instruction + npc).
- `SKID`, default 1: 1 gives a two-entry skid buffer with registered `in_ready`; 0 gives a single entry with combinational `in_ready`.
- `FLUSH_VAL`, default `'0`: `DATA_W`-bit bubble value loaded on reset and on flush (e.g. NOP encoding).

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: upstream payload valid.
- `in_ready` out 1: stage can accept a payload.
- `in_data` in `DATA_W`: upstream payload.
- `out_valid` out 1: head payload available.
- `out_ready` in 1: downstream accepts the head.
- `out_data` out `DATA_W`: head payload.
- `flush` in 1: discard all contents.
- `hold` in 1: freeze the stage (memory not ready).
- `occupancy` out 2: number of valid entries, 0..2.

## Operation
- Storage:
  - `main` (head) register plus valid bit.
  - When `SKID`=1, an additional `skid` register plus valid bit.
  - `out_data` = `main` at all times.
- States and occupancy: EMPTY=0, ONE=1, TWO=2. TWO exists only when `SKID`=1.
- Handshake:
  - `out_valid` = `main` valid & ~`hold`.
  - `SKID`=1: `in_ready` = ~`skid` valid & ~`hold`. This depends only on registered state and `hold`.
  - `SKID`=0: `in_ready` = (~`main` valid | `out_ready`) & ~`hold`.
  - Input transfer (IX) = `in_valid` & `in_ready`.
  - Output transfer (OX) = `out_valid` & `out_ready`.
- Transitions when no flush:
  - EMPTY, IX: `main` <= `in_data`, go to ONE.
  - ONE, IX & OX: `main` <= `in_data`, stay in ONE.
  - ONE, IX only (`SKID`=1): `skid` <= `in_data`, go to TWO.
  - ONE, OX only: go to EMPTY. `main` data is retained, not cleared.
  - TWO, OX: `main` <= `skid`, go to ONE. IX is impossible in TWO.
  - No transfer: all state is held.
- Hold:
  - Forces `in_ready`=0 and `out_valid`=0, so no transfer occurs.
  - State and data are frozen.
- Flush:
  - Highest priority; takes effect even when `hold`=1.
  - At the clock edge, both valid bits clear and `main`/`skid` <= `FLUSH_VAL`.
  - Any IX or OX qualified in the flush cycle is discarded. Upstream and downstream must treat a flush cycle as no transfer.
- Ordering: payloads leave strictly in arrival order. No loss or duplication except on flush.

## Timing
- Reset (async, immediate): `out_valid`=0, `occupancy`=0, `out_data`=`FLUSH_VAL`, skid data=`FLUSH_VAL`. `in_ready`=1 unless `hold`=1.
- Latency:
  - Payload accepted at edge N appears on `out_data` with `out_valid`=1 in cycle N+1 (after edge N), when the stage was EMPTY or ONE-with-OX.
  - A payload parked in `skid` reaches the head one edge after the OX that frees `main`.
- Throughput: 1 payload/cycle in steady state for both `SKID` values.
- `SKID`=1, `in_ready` falls the cycle after entering TWO. A downstream stall therefore never combinationally reaches upstream.
- `occupancy` updates on the same edge as state.
- Reset mid-operation: all payloads are lost, and outputs revert asynchronously to the reset values above.
- `hold` and `flush` are sampled at the clock edge. `hold` affects `in_ready`/`out_valid` combinationally in the same cycle.

## Test plan
- **Reset and flush state:** `DATA_W`=64, `FLUSH_VAL`=0x13, assert `RST` mid-cycle -> immediately `out_valid`=0, `occupancy`=0, `out_data`=0x13.
- **Streaming:** `SKID`=1, `out_ready`=1, push 0x1..0x8 back-to-back -> outputs 0x1..0x8 on consecutive cycles, 1 cycle after input. `occupancy` stays at 1, `in_ready` stays 1.
- **Downstream stall and drain:** push A, B, C with `out_ready`=0 -> A and B accepted, `occupancy`=2, `in_ready`=0 and C held upstream. Then raise `out_ready` -> A, B, C delivered in order.
- **Hold:** `occupancy`=1 with payload 0xAA, `hold`=1 for 3 cycles with `in_valid`=`out_ready`=1 -> `in_ready`=0, `out_valid`=0, state unchanged. Release -> 0xAA transfers.
- **Flush:** `occupancy`=2, `flush`=1 together with `in_valid`=1 and `hold`=1 -> next cycle `occupancy`=0, `out_data`=`FLUSH_VAL`, and the input payload never appears.
- **`SKID`=0:** `main` valid, `out_ready`=1, `in_valid`=1 -> `in_ready`=1 in the same cycle, and the payload replaces the head at the edge. With `out_ready`=0 -> `in_ready`=0.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional two-entry skid
// buffer, flush to a bubble value and a global hold.
module pipeline_stage_reg #(
  parameter int                 DATA_W    = 64,
  parameter int                 SKID      = 1,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of valid entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic main_v;
  logic skid_v;
  logic ix;
  logic ox;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == TWO);

  // Handshake: a payload moves on a side only in a cycle where that side's
  // valid and ready are both high at the rising edge; valid must not depend
  // on ready, and hold forces both ready and valid low so nothing moves.
  // A flush cycle counts as no transfer on either side.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~skid_v & ~hold;
    end else begin : g_noskid
      assign in_ready = (~main_v | out_ready) & ~hold;
    end
  endgenerate

  assign out_valid = main_v & ~hold;
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign ix = in_valid & in_ready;
  assign ox = out_valid & out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (ix) begin
            main_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (ix && ox) begin
            main_q <= in_data;
          end else if (ix) begin
            // Only reachable with SKID=1: with SKID=0 an IX in ONE implies OX.
            skid_q  <= in_data;
            state_q <= TWO;
          end else if (ox) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (ox) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: one SKID=1 and one SKID=0 instance,
// each scenario in its own task with inline expected values.
module tb_pipeline_stage_reg;

  localparam int DW = 64;
  localparam logic [DW-1:0] FV = 64'h13;

  logic          clk;
  logic          rst;

  logic          in_valid, in_ready, out_valid, out_ready, flush, hold;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;

  logic          in_valid0, in_ready0, out_valid0, out_ready0, flush0, hold0;
  logic [DW-1:0] in_data0, out_data0;
  logic [1:0]    occupancy0;

  int n_checks;
  int n_fail;

  pipeline_stage_reg #(.DATA_W(DW), .SKID(1), .FLUSH_VAL(FV)) dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .hold(hold), .occupancy(occupancy)
  );

  pipeline_stage_reg #(.DATA_W(DW), .SKID(0), .FLUSH_VAL(FV)) dut0 (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .flush(flush0), .hold(hold0), .occupancy(occupancy0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Put one payload in, then assert reset between edges.
    in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd1) begin n_fail++; $display("FAIL pre_reset_occ got %0d want 1", occupancy); end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_checks++;
    if (out_data !== FV) begin n_fail++; $display("FAIL reset_out_data got %h want %h", out_data, FV); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (out_data0 !== FV || occupancy0 !== 2'd0) begin
      n_fail++; $display("FAIL reset_skid0 got data=%h occ=%0d want %h/0", out_data0, occupancy0, FV);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(i)) begin
        n_fail++; $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 64'(i));
      end
      n_checks++;
      if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain got occ=%0d v=%b want 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_stall_drain();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA1;
    tick();
    in_data = 64'hB2;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_one got %b want 1", in_ready); end
    tick();
    in_data = 64'hC3;
    n_checks++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL stall_occ got %0d want 2", occupancy); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    tick();
    n_checks++;
    if (occupancy !== 2'd2 || out_data !== 64'hA1) begin
      n_fail++; $display("FAIL stall_held got occ=%0d d=%h want 2/a1", occupancy, out_data);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hA1) begin
      n_fail++; $display("FAIL drain_a got v=%b d=%h want 1/a1", out_valid, out_data);
    end
    tick();
    n_checks++;
    if (out_data !== 64'hB2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_b got d=%h occ=%0d rdy=%b want b2/1/1", out_data, occupancy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_data !== 64'hC3 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL drain_c got d=%h occ=%0d want c3/1", out_data, occupancy);
    end
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty got occ=%0d v=%b want 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hAA;
    tick();
    hold = 1'b1; in_data = 64'hBB; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL hold_hs[%0d] got rdy=%b v=%b want 0/0", i, in_ready, out_valid);
      end
      tick();
      n_checks++;
      if (occupancy !== 2'd1 || out_data !== 64'hAA) begin
        n_fail++; $display("FAIL hold_state[%0d] got occ=%0d d=%h want 1/aa", i, occupancy, out_data);
      end
    end
    hold = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hAA) begin
      n_fail++; $display("FAIL hold_release got v=%b d=%h want 1/aa", out_valid, out_data);
    end
    tick();
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL hold_after got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11;
    tick();
    in_data = 64'h22;
    tick();
    n_checks++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
    flush = 1'b1; hold = 1'b1; in_data = 64'h33;
    tick();
    flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 2'd0 || out_data !== FV || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_state got occ=%0d d=%h v=%b want 0/%h/0", occupancy, out_data, out_valid, FV);
    end
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== FV) begin
      n_fail++; $display("FAIL flush_no_ghost got v=%b d=%h want 0/%h", out_valid, out_data, FV);
    end
    in_valid = 1'b1; in_data = 64'h44;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h44) begin
      n_fail++; $display("FAIL flush_recover got v=%b d=%h want 1/44", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_skid0();
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 64'h5;
    #1;
    n_checks++;
    if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL s0_empty_ready got %b want 1", in_ready0); end
    tick();
    in_data0 = 64'h6;
    #1;
    n_checks++;
    if (occupancy0 !== 2'd1 || out_data0 !== 64'h5 || out_valid0 !== 1'b1) begin
      n_fail++; $display("FAIL s0_first got occ=%0d d=%h v=%b want 1/5/1", occupancy0, out_data0, out_valid0);
    end
    n_checks++;
    if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL s0_stall_ready got %b want 0", in_ready0); end
    tick();
    n_checks++;
    if (occupancy0 !== 2'd1 || out_data0 !== 64'h5) begin
      n_fail++; $display("FAIL s0_stall_hold got occ=%0d d=%h want 1/5", occupancy0, out_data0);
    end
    out_ready0 = 1'b1;
    #1;
    n_checks++;
    if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL s0_pass_ready got %b want 1", in_ready0); end
    tick();
    in_valid0 = 1'b0;
    n_checks++;
    if (occupancy0 !== 2'd1 || out_data0 !== 64'h6) begin
      n_fail++; $display("FAIL s0_replace got occ=%0d d=%h want 1/6", occupancy0, out_data0);
    end
    tick();
    n_checks++;
    if (occupancy0 !== 2'd0 || out_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL s0_empty got occ=%0d v=%b want 0/0", occupancy0, out_valid0);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0; flush0 = 1'b0; hold0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_streaming();
    test_stall_drain();
    test_hold();
    test_flush();
    test_skid0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
